wb_arb2: RTL and testbench

Two-master to one-slave Wishbone classic arbiter with round-robin grant and a bus-timeout watchdog. It sits between the LM32 instruction and data ports and a single shared slave such as the block RAM, and replaces the full crossbar in minimal builds. Grant is registered and held for the whole bus cycle, so the slave always sees one master's transaction from start to end. A watchdog terminates any slave access that never acknowledges.

---
 rtl/wb_arb2.sv | 156 +++++++++++++++
 tb/tb_wb_arb2.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arb2
//  Brief    : Two-master to one-slave Wishbone classic arbiter. Round-robin
//             grant held for a whole bus cycle, plus a watchdog that ends any
//             slave access which never terminates.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arb2 #(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    // master 0 (instruction)
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [DAT_W-1:0]   m0_dat_i,
    output logic [DAT_W-1:0]   m0_dat_o,
    input  logic [DAT_W/8-1:0] m0_sel_i,
    input  logic               m0_we_i,
    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    output logic               m0_rty_o,
    // master 1 (data)
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [DAT_W-1:0]   m1_dat_i,
    output logic [DAT_W-1:0]   m1_dat_o,
    input  logic [DAT_W/8-1:0] m1_sel_i,
    input  logic               m1_we_i,
    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic               m1_rty_o,
    // shared slave
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    output logic [DAT_W/8-1:0] s_sel_o,
    output logic               s_we_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    input  logic [DAT_W-1:0]   s_dat_i,
    input  logic               s_ack_i,
    input  logic               s_err_i,
    input  logic               s_rty_i,
    // debug: one-hot current owner
    output logic [1:0]         gnt_o
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_G0    = 2'd1;
    localparam logic [1:0]  c_ST_G1    = 2'd2;
    localparam logic [15:0] c_WD_LIMIT = 16'(TIMEOUT);
    localparam logic        c_WD_EN    = (TIMEOUT != 0);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_last;      // last winner: 0 = master 0, 1 = master 1
    logic [15:0] r_wd;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_own_stb;
    logic        w_term;
    logic        w_wd_fire;
    logic        w_wd_inc;
    logic        w_state_chg;

    // Next-state: grant from idle by round-robin, hold while owner's cyc is high,
    // hand off directly when the other master is already waiting.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = r_last ? c_ST_G0 : c_ST_G1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = c_ST_G0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = c_ST_G1;
                end
            end
            c_ST_G0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt = m1_cyc_i ? c_ST_G1 : c_ST_IDLE;
                end
            end
            c_ST_G1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt = m0_cyc_i ? c_ST_G0 : c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign w_state_chg = (w_state_nxt != r_state);

    // State and last-winner registers; last records every entry into a grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_chg && (w_state_nxt == c_ST_G0)) begin
                r_last <= 1'b0;
            end else if (w_state_chg && (w_state_nxt == c_ST_G1)) begin
                r_last <= 1'b1;
            end
        end
    end

    assign w_gnt0 = (r_state == c_ST_G0);
    assign w_gnt1 = (r_state == c_ST_G1);
    assign gnt_o  = {w_gnt1, w_gnt0};

    // Slave side follows the owner; master 0 is the idle default for the data path.
    assign s_adr_o   = w_gnt1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o   = w_gnt1 ? m1_dat_i : m0_dat_i;
    assign s_sel_o   = w_gnt1 ? m1_sel_i : m0_sel_i;
    assign s_we_o    = w_gnt1 ? m1_we_i  : m0_we_i;
    assign s_cyc_o   = (w_gnt0 & m0_cyc_i) | (w_gnt1 & m1_cyc_i);
    assign w_own_stb = (w_gnt0 & m0_stb_i) | (w_gnt1 & m1_stb_i);
    assign s_stb_o   = w_own_stb & ~w_wd_fire;

    // A slave termination in the limit cycle wins over the watchdog.
    assign w_term    = s_ack_i | s_err_i | s_rty_i;
    assign w_wd_fire = c_WD_EN & (r_wd == c_WD_LIMIT) & ~w_term;
    assign w_wd_inc  = s_cyc_o & s_stb_o & ~w_term;

    // Watchdog counts stalled strobe cycles; any break in the stall restarts it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wd <= 16'd0;
        end else if (w_wd_inc && !w_state_chg) begin
            r_wd <= r_wd + 16'd1;
        end else begin
            r_wd <= 16'd0;
        end
    end

    // Terminations are combinational and reach the owner only.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = w_gnt0 & s_ack_i;
    assign m0_err_o = w_gnt0 & (s_err_i | w_wd_fire);
    assign m0_rty_o = w_gnt0 & s_rty_i;
    assign m1_ack_o = w_gnt1 & s_ack_i;
    assign m1_err_o = w_gnt1 & (s_err_i | w_wd_fire);
    assign m1_rty_o = w_gnt1 & s_rty_i;

endmodule
`default_nettype wire

// File: tb/tb_wb_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arb2
//  Brief    : Self-checking bench for wb_arb2. Directed stimulus pushes the
//             expected terminations into a scoreboard queue; a monitor pops
//             and compares whenever a master sees ack/err/rty.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arb2;

    logic        clk;
    logic        rst_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i;
    logic        m1_we_i, m1_cyc_i, m1_stb_i;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i, s_rty_i;
    logic        m1_cyc_nw, m1_stb_nw;

    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [1:0]  gnt_o;

    logic [31:0] nw_m0_dat_o, nw_m1_dat_o, nw_s_adr_o, nw_s_dat_o;
    logic [3:0]  nw_s_sel_o;
    logic        nw_m0_ack_o, nw_m0_err_o, nw_m0_rty_o, nw_m1_ack_o, nw_m1_err_o, nw_m1_rty_o;
    logic        nw_s_we_o, nw_s_cyc_o, nw_s_stb_o;
    logic [1:0]  nw_gnt_o;

    wb_arb2 #(.ADR_W(32), .DAT_W(32), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .gnt_o(gnt_o)
    );

    // Watchdog-disabled instance; its master 1 has private cyc/stb.
    wb_arb2 #(.ADR_W(32), .DAT_W(32), .TIMEOUT(0)) dut_nowd (
        .clk_i(clk), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(nw_m0_dat_o), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_ack_o(nw_m0_ack_o), .m0_err_o(nw_m0_err_o), .m0_rty_o(nw_m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(nw_m1_dat_o), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_nw), .m1_stb_i(m1_stb_nw),
        .m1_ack_o(nw_m1_ack_o), .m1_err_o(nw_m1_err_o), .m1_rty_o(nw_m1_rty_o),
        .s_adr_o(nw_s_adr_o), .s_dat_o(nw_s_dat_o), .s_sel_o(nw_s_sel_o), .s_we_o(nw_s_we_o),
        .s_cyc_o(nw_s_cyc_o), .s_stb_o(nw_s_stb_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .gnt_o(nw_gnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        m;       // expected master
        logic        err;     // 1 = error, 0 = ack
        logic        chk_dat; // compare read data
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic m, input logic err, input logic chkd, input logic [31:0] dat);
        exp_t e;
        e.m = m; e.err = err; e.chk_dat = chkd; e.dat = dat;
        sb.push_back(e);
    endtask

    // Monitor: any termination seen by a master must match the next expectation.
    exp_t mon_e;
    logic mon_m, mon_err, mon_ok;
    logic [31:0] mon_dat;
    always @(negedge clk) begin
        if (m0_ack_o | m0_err_o | m0_rty_o | m1_ack_o | m1_err_o | m1_rty_o) begin
            n_cmp++;
            mon_m   = m1_ack_o | m1_err_o | m1_rty_o;
            mon_err = m0_err_o | m1_err_o;
            mon_dat = mon_m ? m1_dat_o : m0_dat_o;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_term actual m0 aer=%b%b%b m1 aer=%b%b%b required none",
                         m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o);
            end else begin
                mon_e  = sb.pop_front();
                mon_ok = (mon_m == mon_e.m) && (mon_err == mon_e.err)
                      && !(m0_rty_o | m1_rty_o)
                      && !((m0_ack_o | m0_err_o) && (m1_ack_o | m1_err_o))
                      && (!mon_e.chk_dat || (mon_dat == mon_e.dat));
                if (!mon_ok) begin
                    n_bad++;
                    $display("FAIL term actual m=%0d err=%0d dat=%h required m=%0d err=%0d dat=%h",
                             mon_m, mon_err, mon_dat, mon_e.m, mon_e.err, mon_e.dat);
                end
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=expired required=finish");
        $fatal(1, "bench timeout");
    end

    int errcnt;

    // Directed stimulus.
    initial begin
        rst_i = 1'b1;
        m0_adr_i = '0; m0_dat_i = 32'h0000_00A0; m0_sel_i = 4'hF; m0_we_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = 32'h0000_00A1; m1_sel_i = 4'h3; m1_we_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        m1_cyc_nw = 1'b0; m1_stb_nw = 1'b0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        tick(); tick();

        // reset state
        @(negedge clk);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        chk("rst_s_stb", 32'(s_stb_o), 32'd0);
        chk("rst_terms", 32'({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}), 32'd0);
        tick(); rst_i = 1'b0;
        tick();

        // m0 single read, ack one cycle after stb reaches slave
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h100;
        @(negedge clk); chk("t1_latency_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_s_cyc", 32'(s_cyc_o), 32'd1);
        chk("t1_gnt", 32'(gnt_o), 32'd1);
        chk("t1_s_adr", s_adr_o, 32'h100);
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF; push_exp(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        @(negedge clk); chk("t1_m0_ack", 32'(m0_ack_o), 32'd1); chk("t1_m1_ack", 32'(m1_ack_o), 32'd0);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick(); tick();

        // simultaneous contention after reset: m0 first, direct handoff to m1
        rst_i = 1'b1; tick(); rst_i = 1'b0; tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h200;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h300;
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hA0A0A0A0; push_exp(1'b0, 1'b0, 1'b1, 32'hA0A0A0A0);
        @(negedge clk); chk("t2_first_gnt", 32'(gnt_o), 32'd1); chk("t2_s_adr0", s_adr_o, 32'h200);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk); chk("t2_drop_s_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'h11112222; push_exp(1'b1, 1'b0, 1'b1, 32'h11112222);
        @(negedge clk);
        chk("t2_handoff_gnt", 32'(gnt_o), 32'd2);
        chk("t2_handoff_cyc", 32'(s_cyc_o), 32'd1);
        chk("t2_s_adr1", s_adr_o, 32'h300);
        tick();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'h33334444; push_exp(1'b0, 1'b0, 1'b1, 32'h33334444);
        @(negedge clk); chk("t2_rr_second", 32'(gnt_o), 32'd1);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'h55556666; push_exp(1'b1, 1'b0, 1'b1, 32'h55556666);
        @(negedge clk); chk("t2_rr_m1", 32'(gnt_o), 32'd2);
        tick();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick(); tick();

        // m1 burst of four beats, m0 waits without preempting
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h400;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h600;
        for (int i = 0; i < 4; i++) begin
            m1_adr_i = 32'h400 + 32'(4 * i);
            s_ack_i = 1'b1; s_dat_i = 32'hB000_0000 + 32'(i);
            push_exp(1'b1, 1'b0, 1'b1, 32'hB000_0000 + 32'(i));
            @(negedge clk);
            chk($sformatf("t3_beat%0d_adr", i), s_adr_o, 32'h400 + 32'(4 * i));
            chk($sformatf("t3_beat%0d_gnt", i), 32'(gnt_o), 32'd2);
            tick();
        end
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        @(negedge clk); chk("t3_no_preempt", 32'(gnt_o), 32'd2);
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hC0C0C0C0; push_exp(1'b0, 1'b0, 1'b1, 32'hC0C0C0C0);
        @(negedge clk); chk("t3_m0_after", 32'(gnt_o), 32'd1); chk("t3_m0_adr", s_adr_o, 32'h600);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick(); tick();

        // watchdog: m1 write never acked, err 9 cycles after first stb
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h500;
        push_exp(1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k <= 10; k++) begin
            if (k == 5) begin
                m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h700;
            end
            @(negedge clk);
            chk($sformatf("t4_err_k%0d", k), 32'(m1_err_o), 32'(k == 9));
            chk($sformatf("t4_stb_k%0d", k), 32'(s_stb_o), 32'((k >= 1) && (k != 9)));
            tick();
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        @(negedge clk); chk("t4_hold_gnt", 32'(gnt_o), 32'd2);
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hD0D0D0D0; push_exp(1'b0, 1'b0, 1'b1, 32'hD0D0D0D0);
        @(negedge clk); chk("t4_m0_after", 32'(gnt_o), 32'd1);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick(); tick();

        // ack exactly at the limit: ack wins, no err
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h800;
        for (int k = 0; k < 9; k++) begin
            tick();
        end
        s_ack_i = 1'b1; s_dat_i = 32'h55AA55AA; push_exp(1'b1, 1'b0, 1'b1, 32'h55AA55AA);
        @(negedge clk); chk("t5_no_err", 32'(m1_err_o), 32'd0); chk("t5_ack", 32'(m1_ack_o), 32'd1);
        tick();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick(); tick();

        // watchdog disabled: 1000-cycle stall never errors
        m1_cyc_nw = 1'b1; m1_stb_nw = 1'b1;
        errcnt = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (nw_m1_err_o) errcnt++;
            tick();
        end
        @(negedge clk);
        chk("t6_nowd_errs", 32'(errcnt), 32'd0);
        chk("t6_nowd_gnt", 32'(nw_gnt_o), 32'd2);
        chk("t6_nowd_stb", 32'(nw_s_stb_o), 32'd1);
        tick();
        m1_cyc_nw = 1'b0; m1_stb_nw = 1'b0;
        tick(); tick();

        // reset during m0 transfer
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h900;
        tick();
        rst_i = 1'b1;
        @(negedge clk); chk("t7_pre_gnt", 32'(gnt_o), 32'd1);
        tick();
        s_ack_i = 1'b1;
        @(negedge clk);
        chk("t7_rst_s_cyc", 32'(s_cyc_o), 32'd0);
        chk("t7_rst_gnt", 32'(gnt_o), 32'd0);
        chk("t7_rst_terms", 32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 32'd0);
        tick();
        rst_i = 1'b0; s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hE0E0E0E0; push_exp(1'b0, 1'b0, 1'b1, 32'hE0E0E0E0);
        @(negedge clk); chk("t7_after_rst_gnt", 32'(gnt_o), 32'd1);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hF0F0F0F0; push_exp(1'b1, 1'b0, 1'b1, 32'hF0F0F0F0);
        tick();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick(); tick();

        chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
